// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared constants for the instruction fetch stage
// Revision  : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

   typedef logic [0:0] state_t;

   localparam state_t FETCH = 1'b0;
   localparam state_t ISSUE = 1'b1;

   localparam int INSTR_W   = 32;
   localparam int PC_INCR   = 4;

   localparam int COND_MSB  = 31;
   localparam int OP_MSB    = 27;
   localparam int FUNCT_MSB = 25;
   localparam int RD_MSB    = 15;

endpackage

`default_nettype wire

// File: rtl/pc_register.sv
// ============================================================================
// pc_register : program counter with load enable, async active-low reset
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_register #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] d,
   output logic [ADDR_W-1:0] q
);

   logic [ADDR_W-1:0] r_pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_PC;
      end else if (load) begin
         r_pc <= d;
      end
   end

   assign q = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC, instruction-memory req/ack fetch and field decode
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_ack,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                exec_done,
   input  logic                pc_src,
   input  logic [ADDR_W-1:0]   branch_target,
   output logic                instr_valid,
   output logic [INSTR_W-1:0]  instr,
   output logic [3:0]          Cond,
   output logic [1:0]          Op,
   output logic [5:0]          Funct,
   output logic [3:0]          Rd,
   output logic [ADDR_W-1:0]   pc_plus8
);

   state_t               r_state;
   logic                 r_req;
   logic                 r_valid;
   logic [INSTR_W-1:0]   r_instr;

   logic [ADDR_W-1:0]    w_pc;
   logic [ADDR_W-1:0]    w_pc_next;
   logic                 w_pc_load;
   logic                 w_ack_take;
   logic [1:0]           w_unused_tgt_lsbs;

   assign w_ack_take = (r_state == FETCH) && r_req && imem_ack;
   assign w_pc_load  = (r_state == ISSUE) && exec_done;
   assign w_pc_next  = pc_src ? {branch_target[ADDR_W-1:2], 2'b00}
                              : w_pc + ADDR_W'(PC_INCR);
   assign w_unused_tgt_lsbs = branch_target[1:0];

   pc_register #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk   (clk),
      .reset (reset),
      .load  (w_pc_load),
      .d     (w_pc_next),
      .q     (w_pc)
   );

   // Request is registered so it first rises one edge after reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FETCH;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
         r_instr <= '0;
      end else if (r_state == FETCH) begin
         if (w_ack_take) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= ISSUE;
         end else begin
            r_req   <= 1'b1;
         end
      end else begin
         if (exec_done) begin
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= FETCH;
         end
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = w_pc;
   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign Cond        = r_instr[COND_MSB  -: 4];
   assign Op          = r_instr[OP_MSB    -: 2];
   assign Funct       = r_instr[FUNCT_MSB -: 6];
   assign Rd          = r_instr[RD_MSB    -: 4];
   assign pc_plus8    = w_pc + ADDR_W'(2 * PC_INCR);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        exec_done;
   logic        pc_src;
   logic [31:0] branch_target;
   logic        instr_valid;
   logic [31:0] instr;
   logic [3:0]  Cond;
   logic [1:0]  Op;
   logic [5:0]  Funct;
   logic [3:0]  Rd;
   logic [31:0] pc_plus8;

   int vectors = 0;
   int errors  = 0;

   fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .exec_done     (exec_done),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .Cond          (Cond),
      .Op            (Op),
      .Funct         (Funct),
      .Rd            (Rd),
      .pc_plus8      (pc_plus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      exec_done = 1'b0; pc_src = 1'b0; branch_target = '0;
      #1;
      chk("rst_req",   32'(imem_req),    32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instr,            32'h0);
      chk("rst_cond",  32'(Cond),        32'h0);
      chk("rst_rd",    32'(Rd),          32'h0);
      chk("rst_addr",  imem_addr,        32'h0);
      chk("rst_pc8",   pc_plus8,         32'h8);

      // Immediate ack and exec_done: back-to-back sequential fetches
      @(negedge clk);
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hE0812003; exec_done = 1'b1;
      #1;
      chk("rel_req_comb", 32'(imem_req), 32'h0);
      @(negedge clk);
      chk("seq0_req",   32'(imem_req),    32'h1);
      chk("seq0_addr",  imem_addr,        32'h0);
      chk("seq0_valid", 32'(instr_valid), 32'h0);
      chk("seq0_pc8",   pc_plus8,         32'h8);
      @(negedge clk);
      chk("seq0_iss_valid", 32'(instr_valid), 32'h1);
      chk("seq0_instr",     instr,            32'hE0812003);
      chk("seq0_cond",      32'(Cond),        32'hE);
      chk("seq0_op",        32'(Op),          32'h0);
      chk("seq0_funct",     32'(Funct),       32'h08);
      chk("seq0_rd",        32'(Rd),          32'h2);
      chk("seq0_iss_req",   32'(imem_req),    32'h0);
      @(negedge clk);
      chk("seq1_addr", imem_addr,     32'h4);
      chk("seq1_req",  32'(imem_req), 32'h1);
      @(negedge clk);
      chk("seq1_valid", 32'(instr_valid), 32'h1);
      @(negedge clk);
      chk("seq2_addr", imem_addr,     32'h8);
      chk("seq2_req",  32'(imem_req), 32'h1);

      // Delayed ack with spurious exec_done/branch during FETCH
      imem_ack = 1'b0; exec_done = 1'b1; pc_src = 1'b1; branch_target = 32'h100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wait_req",   32'(imem_req),    32'h1);
         chk("wait_addr",  imem_addr,        32'h8);
         chk("wait_valid", 32'(instr_valid), 32'h0);
      end
      imem_ack = 1'b1; imem_rdata = 32'hE3A0D010; exec_done = 1'b0;
      @(negedge clk);
      chk("late_valid", 32'(instr_valid), 32'h1);
      chk("late_instr", instr,            32'hE3A0D010);

      // Spurious ack during ISSUE; branch inputs ignored without exec_done
      imem_rdata = 32'hDEADBEEF; pc_src = 1'b1; branch_target = 32'h47;
      repeat (2) begin
         @(negedge clk);
         chk("spur_instr", instr,            32'hE3A0D010);
         chk("spur_pc8",   pc_plus8,         32'h10);
         chk("spur_valid", 32'(instr_valid), 32'h1);
      end
      imem_ack = 1'b0; exec_done = 1'b1;
      @(negedge clk);
      chk("br_addr",  imem_addr,        32'h44);
      chk("br_valid", 32'(instr_valid), 32'h0);

      // Branch to top of address space, then sequential wrap to zero
      imem_ack = 1'b1; imem_rdata = 32'hE1A00000; exec_done = 1'b0;
      @(negedge clk);
      chk("top_iss_valid", 32'(instr_valid), 32'h1);
      imem_ack = 1'b0; exec_done = 1'b1; branch_target = 32'hFFFFFFFF;
      @(negedge clk);
      chk("top_addr", imem_addr, 32'hFFFFFFFC);
      chk("top_pc8",  pc_plus8,  32'h4);
      imem_ack = 1'b1; exec_done = 1'b0;
      @(negedge clk);
      chk("top_valid", 32'(instr_valid), 32'h1);
      imem_ack = 1'b0; exec_done = 1'b1; pc_src = 1'b0;
      @(negedge clk);
      chk("wrap_addr", imem_addr,     32'h0);
      chk("wrap_req",  32'(imem_req), 32'h1);

      // Simultaneous ack and exec_done: only current state's event acts
      imem_ack = 1'b1; exec_done = 1'b1; pc_src = 1'b1;
      branch_target = 32'h80; imem_rdata = 32'hE2811001;
      @(negedge clk);
      chk("sim_f_valid", 32'(instr_valid), 32'h1);
      chk("sim_f_pc8",   pc_plus8,         32'h8);
      chk("sim_f_instr", instr,            32'hE2811001);
      imem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("sim_i_addr",  imem_addr,        32'h80);
      chk("sim_i_valid", 32'(instr_valid), 32'h0);
      chk("sim_i_instr", instr,            32'hE2811001);

      // Reset pulsed mid-FETCH with a late ack arriving at release
      imem_ack = 1'b0; exec_done = 1'b0;
      @(negedge clk);
      chk("mid_req", 32'(imem_req), 32'h1);
      reset = 1'b0;
      #1;
      chk("rstf_req",   32'(imem_req),    32'h0);
      chk("rstf_valid", 32'(instr_valid), 32'h0);
      chk("rstf_addr",  imem_addr,        32'h0);
      @(negedge clk);
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      #1;
      chk("relf_req", 32'(imem_req), 32'h0);
      @(negedge clk);
      chk("relf_req2",  32'(imem_req),    32'h1);
      chk("relf_valid", 32'(instr_valid), 32'h0);
      chk("relf_addr",  imem_addr,        32'h0);
      @(negedge clk);
      chk("relf_iss_valid", 32'(instr_valid), 32'h1);
      chk("relf_iss_instr", instr,            32'hDEADBEEF);

      // Reset pulsed mid-ISSUE
      reset = 1'b0;
      #1;
      chk("rsti_valid", 32'(instr_valid), 32'h0);
      chk("rsti_instr", instr,            32'h0);
      chk("rsti_cond",  32'(Cond),        32'h0);
      chk("rsti_pc8",   pc_plus8,         32'h8);
      @(negedge clk);
      reset = 1'b1; imem_ack = 1'b0;
      @(negedge clk);
      chk("reli_req", 32'(imem_req), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
